// File: rtl/trig_cfg_pkg.sv
// Shared definitions for the trigger configuration writer: opcodes, CTRL bits,
// FSM states and trigger command field constants.
package trig_cfg_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRCH  = 2'b01,
        OP_WRALL = 2'b10,
        OP_CTRL  = 2'b11
    } opcode_t;

    localparam int unsigned CTRL_ARM    = 0;
    localparam int unsigned CTRL_DISARM = 1;
    localparam int unsigned CTRL_INIT   = 2;
    localparam int unsigned CTRL_CLRERR = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_DATA = 2'd1,
        WRITE    = 2'd2
    } state_t;

    // Trigger cell command nibble: bit 3 enables the cell, bits 1:0 pick the pattern.
    localparam int unsigned CMD_EN_BIT = 3;
    localparam logic [1:0]  PAT_LOW    = 2'b00;
    localparam logic [1:0]  PAT_POS    = 2'b01;
    localparam logic [1:0]  PAT_NEG    = 2'b10;
    localparam logic [1:0]  PAT_HIGH   = 2'b11;

endpackage

// File: rtl/trig_onehot_dec.sv
// Channel strobe decoder: one-hot on index, all-ones on broadcast, all-zero
// when not valid or when the index lies beyond the channel count.
module trig_onehot_dec #(
    parameter int NCH = 8,
    parameter int CHW = 6
) (
    input  logic [CHW-1:0] idx,
    input  logic           bcast,
    input  logic           valid,
    output logic [NCH-1:0] strobe
);

    always_comb begin
        strobe = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            strobe[i] = valid && (bcast || (idx == CHW'(i)));
        end
    end

endmodule

// File: rtl/trig_cfg_writer.sv
// Host byte stream -> per-channel trigger command writer with arm/init control.
// Optional command readback shadow enabled by defining TRIG_CFG_READBACK_EN.
module trig_cfg_writer
    import trig_cfg_pkg::*;
#(
    parameter int NCH = 8,
    parameter int CHW = 6
) (
    input  logic           CLK,
    input  logic           RSTn,
    input  logic [7:0]     Din,
    input  logic           DinValid,
    output logic           DinReady,
    output logic [3:0]     wCMD,
    output logic [NCH-1:0] wEN,
    output logic           EN,
    output logic           SetInit,
    output logic           Busy,
    output logic           Err
`ifdef TRIG_CFG_READBACK_EN
    ,
    input  logic [CHW-1:0] RdSel,
    output logic [3:0]     RdCMD
`endif
);

    state_t         state;
    state_t         stateNext;
    logic [CHW-1:0] idxReg;
    logic [3:0]     cmdReg;
    logic           bcastReg;

    logic    accept;
    opcode_t op;
    logic    idxLoad;
    logic    allLoad;
    logic    cmdLoad;
    logic    ctrlAccept;
    logic    errSet;

    assign DinReady = RSTn && (state != WRITE);
    assign accept   = DinValid && DinReady;
    assign Busy     = (state != IDLE);
    assign wCMD     = cmdReg;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        op         = opcode_t'(Din[7:6]);
        idxLoad    = 1'b0;
        allLoad    = 1'b0;
        cmdLoad    = 1'b0;
        ctrlAccept = 1'b0;
        errSet     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_WRCH: begin
                            idxLoad   = 1'b1;
                            stateNext = GET_DATA;
                        end
                        OP_WRALL: begin
                            allLoad   = 1'b1;
                            cmdLoad   = 1'b1;
                            stateNext = WRITE;
                        end
                        OP_CTRL: ctrlAccept = 1'b1;
                        default: ;
                    endcase
                end
            end
            GET_DATA: begin
                if (accept) begin
                    cmdLoad   = 1'b1;
                    stateNext = WRITE;
                end
            end
            WRITE: begin
                // Suppressed writes still pass through here; they only raise Err.
                errSet    = EN || (!bcastReg && (32'(idxReg) >= NCH));
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    trig_onehot_dec #(
        .NCH(NCH),
        .CHW(CHW)
    ) uDec (
        .idx   (idxReg),
        .bcast (bcastReg),
        .valid ((state == WRITE) && !EN),
        .strobe(wEN)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            idxReg   <= '0;
            cmdReg   <= '0;
            bcastReg <= 1'b0;
            EN       <= 1'b0;
            SetInit  <= 1'b0;
            Err      <= 1'b0;
        end else begin
            if (idxLoad) begin
                idxReg   <= Din[CHW-1:0];
                bcastReg <= 1'b0;
            end
            if (allLoad) begin
                bcastReg <= 1'b1;
            end
            if (cmdLoad) begin
                cmdReg <= Din[3:0];
            end
            SetInit <= ctrlAccept && Din[CTRL_INIT];
            if (ctrlAccept) begin
                if (Din[CTRL_DISARM] || Din[CTRL_INIT]) begin
                    EN <= 1'b0;
                end else if (Din[CTRL_ARM]) begin
                    EN <= 1'b1;
                end
            end
            if (errSet) begin
                Err <= 1'b1;
            end else if (ctrlAccept && Din[CTRL_CLRERR]) begin
                Err <= 1'b0;
            end
        end
    end

`ifdef TRIG_CFG_READBACK_EN
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [3:0] shadow [NCH];

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (wEN[i]) begin
                    shadow[i] <= cmdReg;
                end
            end
        end
    end

    always_comb begin
        RdCMD = '0;
        if (32'(RdSel) < NCH) begin
            RdCMD = shadow[RdSel[IW-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_trig_cfg_writer.sv
// Self-checking bench for trig_cfg_writer: directed vector table, then random
// byte traffic against a transaction-level reference model.
module tb_trig_cfg_writer;
    import trig_cfg_pkg::*;

    localparam int NCH = 8;
    localparam int CHW = 6;

    logic           CLK = 1'b0;
    logic           RSTn;
    logic [7:0]     Din;
    logic           DinValid;
    logic           DinReady;
    logic [3:0]     wCMD;
    logic [NCH-1:0] wEN;
    logic           EN;
    logic           SetInit;
    logic           Busy;
    logic           Err;
`ifdef TRIG_CFG_READBACK_EN
    logic [CHW-1:0] RdSel;
    logic [3:0]     RdCMD;
`endif

    always #5 CLK = ~CLK;

    trig_cfg_writer #(
        .NCH(NCH),
        .CHW(CHW)
    ) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .Din     (Din),
        .DinValid(DinValid),
        .DinReady(DinReady),
        .wCMD    (wCMD),
        .wEN     (wEN),
        .EN      (EN),
        .SetInit (SetInit),
        .Busy    (Busy),
        .Err     (Err)
`ifdef TRIG_CFG_READBACK_EN
        ,
        .RdSel   (RdSel),
        .RdCMD   (RdCMD)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks the byte protocol at transaction level.
    bit             mEN, mErr, mSI, mInWrite, mWrErr, mWait;
    logic [5:0]     mIdx;
    logic [3:0]     mCmd;
    logic [NCH-1:0] mMask;
    logic [3:0]     mShadow [NCH];

    task automatic modelEdge(input bit rstn, input bit valid, input logic [7:0] din);
        bit acc;
        bit nIn;
        if (!rstn) begin
            mEN = 0; mErr = 0; mSI = 0; mInWrite = 0; mWrErr = 0; mWait = 0;
            mIdx = '0; mCmd = '0; mMask = '0;
            for (int i = 0; i < NCH; i++) mShadow[i] = '0;
            return;
        end
        acc = valid && !mInWrite;
        nIn = 0;
        if (mInWrite) begin
            for (int i = 0; i < NCH; i++) if (mMask[i]) mShadow[i] = mCmd;
            if (mWrErr) mErr = 1;
        end
        mSI = 0;
        if (acc) begin
            if (mWait) begin
                mWait  = 0;
                mCmd   = din[3:0];
                mWrErr = (int'(mIdx) >= NCH) || mEN;
                mMask  = mWrErr ? '0 : (NCH'(1) << mIdx);
                nIn    = 1;
            end else begin
                case (din[7:6])
                    2'b01: begin mWait = 1; mIdx = din[5:0]; end
                    2'b10: begin
                        mCmd   = din[3:0];
                        mWrErr = mEN;
                        mMask  = mEN ? '0 : '1;
                        nIn    = 1;
                    end
                    2'b11: begin
                        if (din[3]) mErr = 0;
                        if (din[1] || din[2]) mEN = 0;
                        else if (din[0]) mEN = 1;
                        mSI = din[2];
                    end
                    default: ;
                endcase
            end
        end
        mInWrite = nIn;
    endtask

    task automatic cycle(input bit rstn, input bit valid, input logic [7:0] din);
        RSTn     = rstn;
        DinValid = valid;
        Din      = din;
        @(posedge CLK);
        #1;
        modelEdge(rstn, valid, din);
    endtask

    task automatic cmpOut(input string tag, input logic [NCH-1:0] eWen, input logic [3:0] eCmd,
                          input bit eEn, input bit eSi, input bit eBusy, input bit eErr, input bit eRdy);
        chk({tag, ".wEN"},      64'(wEN),      64'(eWen));
        chk({tag, ".wCMD"},     64'(wCMD),     64'(eCmd));
        chk({tag, ".EN"},       64'(EN),       64'(eEn));
        chk({tag, ".SetInit"},  64'(SetInit),  64'(eSi));
        chk({tag, ".Busy"},     64'(Busy),     64'(eBusy));
        chk({tag, ".Err"},      64'(Err),      64'(eErr));
        chk({tag, ".DinReady"}, 64'(DinReady), 64'(eRdy));
    endtask

    typedef struct {
        bit             rstn;
        bit             valid;
        logic [7:0]     din;
        logic [NCH-1:0] wen;
        logic [3:0]     cmd;
        bit             en, si, busy, err, rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rstn, bit valid, logic [7:0] din, logic [NCH-1:0] wen,
                                logic [3:0] cmd, bit en, bit si, bit busy, bit err, bit rdy);
        vec_t v;
        v.rstn = rstn; v.valid = valid; v.din = din; v.wen = wen; v.cmd = cmd;
        v.en = en; v.si = si; v.busy = busy; v.err = err; v.rdy = rdy;
        return v;
    endfunction

    initial begin
        logic [1:0] pats [4];
        logic [3:0] c;
        logic [7:0] b;
        bit         r, v;
        int         kind;

        RSTn = 0; DinValid = 0; Din = '0;
`ifdef TRIG_CFG_READBACK_EN
        RdSel = '0;
`endif
        //                 rst v  din    wEN    cmd  EN SI Bsy Err Rdy
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0, 0)); // reset
        tbl.push_back(mk(1, 0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 8'h43, 8'h00, 4'h0, 0, 0, 1, 0, 1)); // WRITE_CH 3
        tbl.push_back(mk(1, 1, 8'h0D, 8'h08, 4'hD, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 8'h00, 4'hD, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 8'h8C, 8'hFF, 4'hC, 0, 0, 1, 0, 0)); // WRITE_ALL
        tbl.push_back(mk(1, 0, 8'h00, 8'h00, 4'hC, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 8'h49, 8'h00, 4'hC, 0, 0, 1, 0, 1)); // invalid ch 9
        tbl.push_back(mk(1, 1, 8'h0B, 8'h00, 4'hB, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 8'h00, 4'hB, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 8'hC8, 8'h00, 4'hB, 0, 0, 0, 0, 1)); // clear Err
        tbl.push_back(mk(1, 1, 8'hC1, 8'h00, 4'hB, 1, 0, 0, 0, 1)); // ARM
        tbl.push_back(mk(1, 1, 8'h42, 8'h00, 4'hB, 1, 0, 1, 0, 1)); // write while armed
        tbl.push_back(mk(1, 1, 8'h0F, 8'h00, 4'hF, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 8'h00, 4'hF, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 8'hC3, 8'h00, 4'hF, 0, 0, 0, 1, 1)); // ARM+DISARM
        tbl.push_back(mk(1, 1, 8'hC5, 8'h00, 4'hF, 0, 1, 0, 1, 1)); // ARM+INIT
        tbl.push_back(mk(1, 0, 8'h00, 8'h00, 4'hF, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 8'h8A, 8'hFF, 4'hA, 0, 0, 1, 1, 0)); // broadcast
        tbl.push_back(mk(1, 1, 8'hC1, 8'h00, 4'hA, 0, 0, 0, 1, 1)); // held during WRITE
        tbl.push_back(mk(1, 1, 8'hC1, 8'h00, 4'hA, 1, 0, 0, 1, 1)); // now accepted
        tbl.push_back(mk(1, 1, 8'hC2, 8'h00, 4'hA, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 8'hC8, 8'h00, 4'hA, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 8'h45, 8'h00, 4'hA, 0, 0, 1, 0, 1)); // reset mid-op
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h0A, 8'h00, 4'h0, 0, 0, 0, 0, 1)); // seen as NOP
        tbl.push_back(mk(1, 0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 8'h45, 8'h00, 4'h0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 8'h0A, 8'h20, 4'hA, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 8'h00, 4'hA, 0, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            cycle(tbl[i].rstn, tbl[i].valid, tbl[i].din);
            cmpOut($sformatf("row%0d", i), tbl[i].wen, tbl[i].cmd, tbl[i].en,
                   tbl[i].si, tbl[i].busy, tbl[i].err, tbl[i].rdy);
        end

`ifdef TRIG_CFG_READBACK_EN
        RdSel = 6'd5;  #1; chk("rb.sel5",  64'(RdCMD), 64'h0A);
        RdSel = 6'd9;  #1; chk("rb.sel9",  64'(RdCMD), 64'h00);
        RdSel = 6'd3;  #1; chk("rb.sel3",  64'(RdCMD), 64'h00);
`endif

        pats = '{PAT_LOW, PAT_POS, PAT_NEG, PAT_HIGH};
        cycle(0, 0, 8'h00);
        cycle(0, 0, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom_range(0, 99) != 0);
            v    = ($urandom_range(0, 9) < 7);
            kind = $urandom_range(0, 3);
            c    = '0;
            c[CMD_EN_BIT] = 1'($urandom_range(0, 1));
            c[1:0]        = pats[$urandom_range(0, 3)];
            case (kind)
                0: b = {2'b01, 6'($urandom_range(0, 11))};
                1: b = {2'b10, 2'($urandom_range(0, 3)), c};
                2: b = {2'b11, 2'b00, 4'($urandom_range(0, 15))};
                default: b = {4'($urandom_range(0, 15)), c};
            endcase
`ifdef TRIG_CFG_READBACK_EN
            RdSel = 6'($urandom_range(0, 11));
`endif
            cycle(r, v, b);
            cmpOut($sformatf("rnd%0d", n), mInWrite ? mMask : '0, mCmd, mEN, mSI,
                   mInWrite || mWait, mErr, r && !mInWrite);
`ifdef TRIG_CFG_READBACK_EN
            chk($sformatf("rnd%0d.RdCMD", n), 64'(RdCMD),
                64'((int'(RdSel) < NCH) ? mShadow[RdSel[2:0]] : 4'h0));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
